// File: rtl/pool_array_if.sv
// Pixel-stream and pooled-frame bundle for pool_array.
// The master drives pixels and frame control; the slave (pool_array) returns the frame.
interface pool_array_if #(
  parameter int CH   = 3,
  parameter int DW   = 8,
  parameter int IN_W = 6,
  parameter int IN_H = 6
);
  localparam int PW = CH * (IN_H / 2) * (IN_W / 2) * DW;

  logic             in_vld;
  logic [CH*DW-1:0] in_data;
  logic             mode;
  logic             clr;
  logic [PW-1:0]    pool_lin;
  logic             out_vld;
  logic             busy;

  modport master (
    output in_vld, in_data, mode, clr,
    input  pool_lin, out_vld, busy
  );

  modport slave (
    input  in_vld, in_data, mode, clr,
    output pool_lin, out_vld, busy
  );
endinterface

// File: rtl/pool_array.sv
// 2x2 stride-2 max/average pooling over a raster pixel stream, CH channels in parallel.
// The finished frame is published as one flat vector one clock after its last pixel.
module pool_array #(
  parameter int CH   = 3,
  parameter int DW   = 8,
  parameter int IN_W = 6,
  parameter int IN_H = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  pool_array_if.slave bus
);
  localparam int OW = IN_W / 2;
  localparam int OH = IN_H / 2;
  localparam int PW = CH * OH * OW * DW;
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int SW = DW + 2;

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Horizontal pair reduction kept in the line buffer: max, or an overflow-free sum.
  function automatic logic [SW-1:0] pair_part(input logic avg, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    if (avg) return SW'(a) + SW'(b);
    return SW'(max2(a, b));
  endfunction

  // Combine the upper-row partial with the lower pair; the average truncates by >>2.
  function automatic logic [DW-1:0] window_res(input logic avg, input logic [SW-1:0] part,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [SW-1:0] sum;
    sum = part + SW'(c) + SW'(d);
    if (avg) return sum[SW-1:2];
    return max2(part[DW-1:0], max2(c, d));
  endfunction

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          mode_q;
  logic [DW-1:0] pair_q [CH];
  logic [SW-1:0] lb_q   [CH][OW];
  logic [PW-1:0] work_q;
  logic [PW-1:0] work_nxt;
  logic [PW-1:0] pool_p1;
  logic          vld_p1;

  logic          beat;
  logic          col_last;
  logic          row_last;
  logic          frame_end;
  logic [DW-1:0] pix    [CH];
  logic [SW-1:0] lb_sel [CH];
  int            slot;
  int            elem;

  // clr dominates in_vld: a cleared beat neither advances nor stores anything
  assign beat      = bus.in_vld && !bus.clr;
  assign col_last  = (col_q == CW'(IN_W - 1));
  assign row_last  = (row_q == RW'(IN_H - 1));
  assign frame_end = beat && col_last && row_last;

  // Unpack pixels, pick the line-buffer slot and build the working array with this beat's result
  always_comb begin
    slot     = int'(col_q) / 2;
    elem     = (int'(row_q) / 2) * OW + slot;
    work_nxt = work_q;
    for (int c = 0; c < CH; c++) begin
      pix[c]    = bus.in_data[c*DW +: DW];
      lb_sel[c] = '0;
      for (int k = 0; k < OW; k++) begin
        if (k == slot) lb_sel[c] = lb_q[c][k];
      end
      if (beat && col_q[0] && row_q[0]) begin
        for (int e = 0; e < OH * OW; e++) begin
          if (e == elem)
            work_nxt[(c*OH*OW + e)*DW +: DW] = window_res(mode_q, lb_sel[c], pair_q[c], pix[c]);
        end
      end
    end
  end

  // Raster position counters and per-frame mode latch (taken on the (0,0) beat)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
    end else if (bus.clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (bus.in_vld) begin
      if (col_q == '0 && row_q == '0) mode_q <= bus.mode;
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Pair registers (even column) and line-buffer partials (odd column, even row)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.clr) begin
      for (int c = 0; c < CH; c++) begin
        pair_q[c] <= '0;
        for (int k = 0; k < OW; k++) lb_q[c][k] <= '0;
      end
    end else if (beat) begin
      for (int c = 0; c < CH; c++) begin
        if (!col_q[0]) begin
          pair_q[c] <= pix[c];
        end else if (!row_q[0]) begin
          for (int k = 0; k < OW; k++) begin
            if (k == slot) lb_q[c][k] <= pair_part(mode_q, pair_q[c], pix[c]);
          end
        end
      end
    end
  end

  // ---- p1: working array update and frame publish one clock after the boundary beat ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      pool_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= frame_end;
      if (beat) work_q <= work_nxt;
      if (frame_end) pool_p1 <= work_nxt;
    end
  end

  assign bus.pool_lin = pool_p1;
  assign bus.out_vld  = vld_p1;
  assign bus.busy     = (col_q != '0) || (row_q != '0);
endmodule

// File: tb/tb_pool_array.sv
// Scoreboarded random/directed bench for pool_array.
module tb_pool_array;
  localparam int CH = 3, DW = 8, IN_W = 6, IN_H = 6;
  localparam int OW = IN_W / 2, OH = IN_H / 2, NP = IN_W * IN_H;
  localparam int PW = CH * OH * OW * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pool_array_if #(.CH(CH), .DW(DW), .IN_W(IN_W), .IN_H(IN_H)) bus ();

  pool_array #(.CH(CH), .DW(DW), .IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fr [CH][NP];
  logic [PW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            pulse_q[$];
  logic [PW-1:0] last_exp = '0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: pool each 2x2 window of the stored frame with plain arithmetic
  function automatic logic [PW-1:0] model(input bit avg);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < OH; i++)
        for (int k = 0; k < OW; k++) begin
          int a, b, d, e, v;
          a = int'(fr[c][(2*i)*IN_W + 2*k]);
          b = int'(fr[c][(2*i)*IN_W + 2*k + 1]);
          d = int'(fr[c][(2*i+1)*IN_W + 2*k]);
          e = int'(fr[c][(2*i+1)*IN_W + 2*k + 1]);
          if (avg) v = (a + b + d + e) / 4;
          else begin
            v = a;
            if (b > v) v = b;
            if (d > v) v = d;
            if (e > v) v = e;
          end
          r[((c*OH + i)*OW + k)*DW +: DW] = DW'(v);
        end
    return r;
  endfunction

  function automatic int elem_of(input logic [PW-1:0] p, input int c, input int r, input int k);
    return int'(p[((c*OH + r)*OW + k)*DW +: DW]);
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NP; i++) begin
      fr[0][i] = DW'(i);
      for (int c = 1; c < CH; c++) fr[c][i] = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < NP; i++) fr[c][i] = DW'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int v);
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < NP; i++) fr[c][i] = DW'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_vld = 1'b0;
      bus.clr    = 1'b0;
    end
  endtask

  task automatic drive_beat(input int i, input bit m, input bit c);
    @(posedge clk); #1;
    bus.in_vld = 1'b1;
    bus.clr    = c;
    bus.mode   = m;
    for (int ch = 0; ch < CH; ch++) bus.in_data[ch*DW +: DW] = fr[ch][i];
  endtask

  // Full frame; the expected result is queued with the cycle its out_vld must appear
  task automatic send_frame(input bit m, input bit gaps, input bit toggle);
    for (int i = 0; i < NP; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      drive_beat(i, (toggle && i > 0) ? bit'($urandom_range(0, 1)) : m, 1'b0);
      if (i == NP - 1) begin
        last_exp = model(m);
        exp_q.push_back(last_exp);
        exp_cyc_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    idle(2);
  endtask

  // Monitor: every out_vld pops one expected frame and its required cycle
  always @(negedge clk) begin
    if (rst_n && bus.out_vld) begin
      pulse_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_vld: got 1 at cycle %0d expected 0", cyc);
      end else begin
        logic [PW-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("frame", bus.pool_lin, e);
        check_val("latency_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    bus.in_vld  = 1'b0;
    bus.clr     = 1'b0;
    bus.mode    = 1'b0;
    bus.in_data = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pool_lin", bus.pool_lin, '0);
    check_val("reset_out_vld", int'(bus.out_vld), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ramp frame, max pooling
    fill_ramp();
    send_frame(1'b0, 1'b0, 1'b0);
    drain();
    check_val("max_00", elem_of(bus.pool_lin, 0, 0, 0), 7);
    check_val("max_11", elem_of(bus.pool_lin, 0, 1, 1), 21);
    check_val("max_22", elem_of(bus.pool_lin, 0, 2, 2), 35);
    check_val("idle_busy", int'(bus.busy), 0);

    // same ramp, average pooling
    send_frame(1'b1, 1'b0, 1'b0);
    drain();
    check_val("avg_00", elem_of(bus.pool_lin, 0, 0, 0), 3);
    check_val("avg_01", elem_of(bus.pool_lin, 0, 0, 1), 5);
    check_val("avg_22", elem_of(bus.pool_lin, 0, 2, 2), 31);

    // all-255 average must not overflow
    fill_const(255);
    send_frame(1'b1, 1'b0, 1'b0);
    drain();
    check("avg_all_255", bus.pool_lin, '1);

    // ramp with gaps and mode wiggling after the first beat
    fill_ramp();
    send_frame(1'b0, 1'b1, 1'b1);
    drain();
    check_val("gap_max_22", elem_of(bus.pool_lin, 0, 2, 2), 35);

    // random frames, gaps, mode wiggling
    repeat (4) begin
      fill_rand();
      m = bit'($urandom_range(0, 1));
      send_frame(m, 1'b1, 1'b1);
      drain();
    end

    // clr after 20 beats, then a full frame
    fill_rand();
    for (int i = 0; i < 20; i++) drive_beat(i, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    check_val("busy_mid_frame", int'(bus.busy), 1);
    @(posedge clk); #1;
    bus.clr = 1'b1;
    idle(1);
    @(negedge clk);
    check_val("busy_after_clr", int'(bus.busy), 0);
    fill_rand();
    send_frame(1'b0, 1'b0, 1'b0);
    drain();

    // clr together with the boundary beat: discarded, no out_vld
    fill_rand();
    for (int i = 0; i < NP - 1; i++) drive_beat(i, 1'b1, 1'b0);
    drive_beat(NP - 1, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    check("clr_last_pool_kept", bus.pool_lin, last_exp);
    check_val("clr_last_busy", int'(bus.busy), 0);

    // reset mid-frame
    fill_rand();
    for (int i = 0; i < 10; i++) drive_beat(i, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    rst_n      = 1'b0;
    #2;
    check("rst_mid_pool", bus.pool_lin, '0);
    check_val("rst_mid_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(1'b1, 1'b0, 1'b0);
    drain();

    // back-to-back frames
    pulse_q.delete();
    fill_rand();
    send_frame(1'b0, 1'b0, 1'b0);
    fill_rand();
    send_frame(1'b1, 1'b0, 1'b0);
    drain();
    check_val("b2b_pulses", pulse_q.size(), 2);
    if (pulse_q.size() >= 2)
      check_val("b2b_spacing", pulse_q[pulse_q.size()-1] - pulse_q[pulse_q.size()-2], NP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
